thread_lsu: RTL and testbench

Per-thread load/store unit. It consumes the register file's rs (address) and rt (store data) and produces lsu_out, the MEMORY-source write-back value, for LDR/STR instructions. It is the memory-side counterpart of the register file. It drives one valid/ready request channel per direction to the core's memory controller and reports its state so the core scheduler can hold in WAIT until all threads' memory operations finish.

---
 rtl/thread_lsu.sv | 182 ++++++++++++++++++
 tb/tb_thread_lsu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_lsu.sv
// Per-thread load/store unit: turns LDR/STR operands into one valid/ready memory request per op.
// Optional build macro LSU_TIMEOUT_EN adds a WAITING-cycle timeout with a sticky lsu_error flag.
module thread_lsu #(
    parameter int unsigned ADDR_BITS      = 8,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [7:0]           rs,
    input  logic [7:0]           rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);

    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_REQUESTING = 2'b01,
        ST_WAITING    = 2'b10,
        ST_DONE       = 2'b11
    } state_t;

    // Reject out-of-range timeout limits at elaboration.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("thread_lsu: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t               state_q,    state_d;
    logic                 op_read_q,  op_read_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0] rd_addr_q,  rd_addr_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0] wr_addr_q,  wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q,  wr_data_d;
    logic [DATA_BITS-1:0] out_q,      out_d;
    logic                 ready_c;

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    // Only the channel belonging to the latched op can complete the request.
    assign ready_c = op_read_q ? mem_read_ready : mem_write_ready;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        op_read_d  = op_read_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        out_d      = out_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (core_state == CORE_REQUEST) begin
                    if (decoded_mem_read_enable) begin
                        op_read_d = 1'b1;
                        state_d   = ST_REQUESTING;
                    end else if (decoded_mem_write_enable) begin
                        op_read_d = 1'b0;
                        state_d   = ST_REQUESTING;
                    end
                end
            end
            ST_REQUESTING: begin
                if (op_read_q) begin
                    rd_valid_d = 1'b1;
                    rd_addr_d  = ADDR_BITS'(rs);
                end else begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = ADDR_BITS'(rs);
                    wr_data_d  = DATA_BITS'(rt);
                end
`ifdef LSU_TIMEOUT_EN
                cnt_d = 16'd0;
`endif
                state_d = ST_WAITING;
            end
            ST_WAITING: begin
                if (ready_c) begin
                    rd_valid_d = 1'b0;
                    wr_valid_d = 1'b0;
                    if (op_read_q) begin
                        out_d = mem_read_data;
                    end
                    state_d = ST_DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if ((cnt_q + 16'd1) == TIMEOUT_LIMIT) begin
                    // Abandon the request; reads return all ones so a stale value is never mistaken for data.
                    rd_valid_d = 1'b0;
                    wr_valid_d = 1'b0;
                    err_d      = 1'b1;
                    cnt_d      = cnt_q + 16'd1;
                    if (op_read_q) begin
                        out_d = '1;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ST_DONE: begin
                if (core_state == CORE_UPDATE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset wins over enable, enable low freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_read_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            out_q      <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= 16'd0;
            err_q      <= 1'b0;
`endif
        end else if (enable) begin
            state_q    <= state_d;
            op_read_q  <= op_read_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            out_q      <= out_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign mem_read_valid    = rd_valid_q;
    assign mem_read_address  = rd_addr_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_write_address = wr_addr_q;
    assign mem_write_data    = wr_data_q;
    assign lsu_state         = state_q;
    assign lsu_out           = out_q;

`ifdef LSU_TIMEOUT_EN
    assign lsu_error = err_q;
`else
    assign lsu_error = 1'b0;
`endif

endmodule

// File: tb/tb_thread_lsu.sv
// Scoreboard bench for thread_lsu: directed loads/stores, enable freeze, reset, optional timeout.
module tb_thread_lsu;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       rd_en, wr_en;
    logic [7:0] rs, rt;
    logic       mem_read_valid, mem_read_ready;
    logic [7:0] mem_read_address, mem_read_data;
    logic       mem_write_valid, mem_write_ready;
    logic [7:0] mem_write_address, mem_write_data;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       lsu_error;

    localparam logic [2:0] C_REQ = 3'b011;
    localparam logic [2:0] C_UPD = 3'b110;
    localparam logic [2:0] C_OTH = 3'b000;

    always #5 clk = ~clk;

    thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
        .rs(rs), .rt(rt),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
    );

    typedef struct {
        logic       is_read;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_out;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic       pend = 1'b0;
    logic [7:0] pend_out;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: pop on every accepted handshake, check lsu_out one cycle later.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (pend) begin
            chk("sb_lsu_out", 32'(lsu_out), 32'(pend_out));
            chk("sb_done_state", 32'(lsu_state), 32'd3);
            pend = 1'b0;
        end
        if (!reset && enable && ((mem_read_valid && mem_read_ready) ||
                                 (mem_write_valid && mem_write_ready))) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: handshake with empty queue at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_channel_rd", 32'(mem_read_valid), 32'(e.is_read));
                chk("sb_channel_wr", 32'(mem_write_valid), 32'(!e.is_read));
                if (e.is_read) begin
                    chk("sb_rd_addr", 32'(mem_read_address), 32'(e.addr));
                end else begin
                    chk("sb_wr_addr", 32'(mem_write_address), 32'(e.addr));
                    chk("sb_wr_data", 32'(mem_write_data), 32'(e.wdata));
                end
                pend     = 1'b1;
                pend_out = e.exp_out;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_read, input logic [7:0] a, input logic [7:0] d, input logic [7:0] o);
        exp_t e;
        e.is_read = is_read; e.addr = a; e.wdata = d; e.exp_out = o;
        sb_q.push_back(e);
    endtask

    // Issue the REQUEST edge; operands stay on rs/rt for the following edge.
    task automatic req(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        core_state = C_REQ; rd_en = rd; wr_en = wr; rs = a; rt = d;
        tick();
        core_state = C_OTH; rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic update();
        core_state = C_UPD;
        tick();
        core_state = C_OTH;
        chk("update_idle", 32'(lsu_state), 32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; core_state = C_OTH; rd_en = 1'b0; wr_en = 1'b0;
        rs = 8'h00; rt = 8'h00; mem_read_ready = 1'b0; mem_read_data = 8'h00; mem_write_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_state", 32'(lsu_state), 32'd0);
        chk("rst_rvalid", 32'(mem_read_valid), 32'd0);
        chk("rst_wvalid", 32'(mem_write_valid), 32'd0);
        chk("rst_out", 32'(lsu_out), 32'd0);
        chk("rst_raddr", 32'(mem_read_address), 32'd0);
        chk("rst_err", 32'(lsu_error), 32'd0);

        // Load 0x2A, ready arrives 3 cycles after valid.
        push(1'b1, 8'h2A, 8'h00, 8'h5C);
        req(1'b1, 1'b0, 8'h2A, 8'h00);
        chk("ld_requesting", 32'(lsu_state), 32'd1);
        chk("ld_no_valid_yet", 32'(mem_read_valid), 32'd0);
        tick();
        rs = 8'h99;
        chk("ld_waiting", 32'(lsu_state), 32'd2);
        for (int i = 0; i < 4; i++) begin
            chk("ld_valid_high", 32'(mem_read_valid), 32'd1);
            chk("ld_addr_stable", 32'(mem_read_address), 32'h2A);
            chk("ld_wvalid_low", 32'(mem_write_valid), 32'd0);
            if (i == 3) begin
                mem_read_ready = 1'b1; mem_read_data = 8'h5C;
            end
            tick();
        end
        mem_read_ready = 1'b0; mem_read_data = 8'h00;
        chk("ld_valid_dropped", 32'(mem_read_valid), 32'd0);
        chk("ld_out", 32'(lsu_out), 32'h5C);
        chk("ld_done", 32'(lsu_state), 32'd3);
        core_state = C_REQ; wr_en = 1'b1;
        tick();
        core_state = C_OTH; wr_en = 1'b0;
        chk("done_ignores_req", 32'(lsu_state), 32'd3);
        update();

        // Store with write ready tied high.
        mem_write_ready = 1'b1;
        push(1'b0, 8'h10, 8'hEE, 8'h5C);
        req(1'b0, 1'b1, 8'h10, 8'hEE);
        chk("st_requesting", 32'(lsu_state), 32'd1);
        tick();
        chk("st_wvalid", 32'(mem_write_valid), 32'd1);
        chk("st_waddr", 32'(mem_write_address), 32'h10);
        chk("st_wdata", 32'(mem_write_data), 32'hEE);
        chk("st_rvalid_low", 32'(mem_read_valid), 32'd0);
        tick();
        chk("st_wvalid_one_cycle", 32'(mem_write_valid), 32'd0);
        chk("st_done_3_edges", 32'(lsu_state), 32'd3);
        chk("st_out_kept", 32'(lsu_out), 32'h5C);
        update();

        // Both enables: read wins; write-channel ready is ignored.
        push(1'b1, 8'h07, 8'h00, 8'hA1);
        req(1'b1, 1'b1, 8'h07, 8'h33);
        tick();
        chk("both_rvalid", 32'(mem_read_valid), 32'd1);
        chk("both_wvalid_low", 32'(mem_write_valid), 32'd0);
        chk("both_raddr", 32'(mem_read_address), 32'h07);
        tick();
        chk("both_wready_ignored", 32'(lsu_state), 32'd2);
        chk("both_wvalid_still_low", 32'(mem_write_valid), 32'd0);

        // Freeze with enable low while ready is offered.
        enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 8'hA1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("en0_valid_held", 32'(mem_read_valid), 32'd1);
            chk("en0_state_held", 32'(lsu_state), 32'd2);
        end
        enable = 1'b1;
        tick();
        mem_read_ready = 1'b0; mem_write_ready = 1'b0;
        chk("en1_complete", 32'(lsu_state), 32'd3);
        chk("en1_out", 32'(lsu_out), 32'hA1);
        update();

        // Reset in the middle of a handshake.
        req(1'b1, 1'b0, 8'h40, 8'h00);
        tick();
        chk("rstw_valid_before", 32'(mem_read_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw_valid", 32'(mem_read_valid), 32'd0);
        chk("rstw_state", 32'(lsu_state), 32'd0);
        chk("rstw_out", 32'(lsu_out), 32'd0);
        chk("rstw_addr", 32'(mem_read_address), 32'd0);

`ifdef LSU_TIMEOUT_EN
        // Timeout after 4 WAITING cycles with no ready.
        req(1'b1, 1'b0, 8'h55, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_valid_high", 32'(mem_read_valid), 32'd1);
            chk("to_err_low", 32'(lsu_error), 32'd0);
            tick();
        end
        chk("to_valid_dropped", 32'(mem_read_valid), 32'd0);
        chk("to_err", 32'(lsu_error), 32'd1);
        chk("to_out_ones", 32'(lsu_out), 32'hFF);
        chk("to_done", 32'(lsu_state), 32'd3);
        update();
        mem_read_ready = 1'b1; mem_read_data = 8'h3C;
        push(1'b1, 8'h01, 8'h00, 8'h3C);
        req(1'b1, 1'b0, 8'h01, 8'h00);
        tick(); tick();
        mem_read_ready = 1'b0;
        chk("to_next_load_done", 32'(lsu_state), 32'd3);
        chk("to_err_sticky", 32'(lsu_error), 32'd1);
        update();
`else
        chk("err_tied_low", 32'(lsu_error), 32'd0);
`endif

        tick(); tick();
        chk("sb_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
